// File: rtl/reg_scoreboard_if.sv
// Decode-stage scoreboard interface: ID hazard query, long-op completion and
// scoreboard status. master drives the request side, slave is the scoreboard.
interface reg_scoreboard_if #(
  parameter int CNT_W = 3
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_write;
  logic             id_is_long;
  logic             flush;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             stall;
  logic             issue_fire;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] outstanding;
  logic             err_spurious_wb;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_is_long, flush, wb_valid, wb_rd,
    input  stall, issue_fire, busy_mask, outstanding, err_spurious_wb
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_reg_write, id_is_long, flush, wb_valid, wb_rd,
    output stall, issue_fire, busy_mask, outstanding, err_spurious_wb
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending long-latency destination writes and stalls ID.
// Optional SCOREBOARD_BYPASS_EN lets a same-cycle completion release its register.
module reg_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic          clk,
  input logic          rst,
  reg_scoreboard_if.slave sb
);
  logic [31:0]      busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [31:0] wb_dec;
  logic [31:0] eff_busy;
  logic        wb_hit;
  logic        release_ok;
  logic        raw, waw, cap;
  logic        stall, issue, do_set;

  assign wb_dec = 32'(1) << sb.wb_rd;
  assign wb_hit = sb.wb_valid & busy_q[sb.wb_rd];

`ifdef SCOREBOARD_BYPASS_EN
  assign eff_busy   = busy_q & ~(sb.wb_valid ? wb_dec : '0);
  assign release_ok = wb_hit;
`else
  assign eff_busy   = busy_q;
  assign release_ok = 1'b0;
`endif

  assign raw = (sb.id_uses_rs1 & eff_busy[sb.id_rs1]) |
               (sb.id_uses_rs2 & eff_busy[sb.id_rs2]);
  assign waw = sb.id_reg_write & (sb.id_rd != 5'd0) & eff_busy[sb.id_rd];
  assign cap = sb.id_is_long & sb.id_reg_write &
               (cnt_q == CNT_W'(MAX_OUTSTANDING)) & ~release_ok;

  assign stall  = sb.id_valid & ~sb.flush & (raw | waw | cap);
  assign issue  = sb.id_valid & ~sb.flush & ~stall;
  assign do_set = issue & sb.id_is_long & sb.id_reg_write & (sb.id_rd != 5'd0);

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    // Clear before set: with bypass a new producer may reuse the register
    // being released this cycle, and its busy bit must survive.
    if (wb_hit) busy_d[sb.wb_rd] = 1'b0;
    if (do_set) busy_d[sb.id_rd] = 1'b1;
    busy_d[0] = 1'b0;
    case ({do_set, wb_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    // busy_q[0] is always 0, so a completion to x0 is also flagged here.
    if (sb.wb_valid & ~wb_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb.stall           = stall;
  assign sb.issue_fire      = issue;
  assign sb.busy_mask       = busy_q;
  assign sb.outstanding     = cnt_q;
  assign sb.err_spurious_wb = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic against a set-of-pending-registers reference model.
module tb_reg_scoreboard;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_scoreboard_if #(.CNT_W(CW)) sb ();

  reg_scoreboard #(.MAX_OUTSTANDING(MAXO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  // Reference model: set of registers awaiting a long-latency result.
  bit m_busy[32];
  int m_cnt;
  bit m_err;

  function automatic bit byp();
`ifdef SCOREBOARD_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
  endfunction

  function automatic bit m_eff(input int r);
    if (r == 0) return 1'b0;
    return m_busy[r] && !(byp() && sb.wb_valid && int'(sb.wb_rd) == r);
  endfunction

  function automatic bit m_stall();
    bit raw, waw, cap;
    if (!sb.id_valid || sb.flush) return 1'b0;
    raw = (sb.id_uses_rs1 && m_eff(int'(sb.id_rs1))) ||
          (sb.id_uses_rs2 && m_eff(int'(sb.id_rs2)));
    waw = sb.id_reg_write && sb.id_rd != 0 && m_eff(int'(sb.id_rd));
    cap = sb.id_is_long && sb.id_reg_write && m_cnt == MAXO &&
          !(byp() && sb.wb_valid && m_busy[sb.wb_rd]);
    return raw || waw || cap;
  endfunction

  function automatic bit m_issue();
    return sb.id_valid && !sb.flush && !m_stall();
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 1; i < 32; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2,
                        input bit u2, input int rd, input bit rw, input bit lng);
    sb.id_valid     = v;
    sb.id_rs1       = 5'(rs1);
    sb.id_uses_rs1  = u1;
    sb.id_rs2       = 5'(rs2);
    sb.id_uses_rs2  = u2;
    sb.id_rd        = 5'(rd);
    sb.id_reg_write = rw;
    sb.id_is_long   = lng;
  endtask

  task automatic set_wb(input bit v, input int rd);
    sb.wb_valid = v;
    sb.wb_rd    = 5'(rd);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    sb.flush = 1'b0;
  endtask

  // Advance one clock, applying the model's rules for the inputs now driven.
  task automatic tick();
    bit iss;
    iss = m_issue();
    @(posedge clk);
    if (sb.wb_valid) begin
      if (sb.wb_rd != 0 && m_busy[sb.wb_rd]) begin
        m_busy[sb.wb_rd] = 1'b0;
        m_cnt--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (iss && sb.id_is_long && sb.id_reg_write && sb.id_rd != 0) begin
      m_busy[sb.id_rd] = 1'b1;
      m_cnt++;
    end
    #1;
  endtask

  task automatic drain();
    for (int r = 1; r < 32; r++) begin
      if (m_busy[r]) begin
        idle();
        set_wb(1, r);
        tick();
      end
    end
    idle();
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (sb.busy_mask !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", sb.busy_mask); end
    total++; if (sb.outstanding !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", sb.outstanding); end
    total++; if (sb.err_spurious_wb !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", sb.err_spurious_wb); end
    rst = 1'b0;
    set_id(0, 5, 1, 6, 1, 7, 1, 1);
    #1;
    total++; if (sb.stall !== 1'b0 || sb.issue_fire !== 1'b0)
      begin bad++; $display("FAIL reset_idle got=%b%b exp=00", sb.stall, sb.issue_fire); end
    tick();
  endtask

  task automatic test_load_use();
    set_id(1, 0, 0, 0, 0, 5, 1, 1);
    #1;
    total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL lu_issue got=%b exp=1", sb.issue_fire); end
    tick();
    total++; if (sb.busy_mask !== 32'h20) begin bad++; $display("FAIL lu_mask got=%h exp=20", sb.busy_mask); end
    set_id(1, 5, 1, 0, 0, 8, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (sb.stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", sb.stall); end
      tick();
    end
    set_wb(1, 5);
    #1;
    total++; if (sb.issue_fire !== byp()) begin bad++; $display("FAIL lu_wb_issue got=%b exp=%b", sb.issue_fire, byp()); end
    total++; if (sb.stall !== !byp()) begin bad++; $display("FAIL lu_wb_stall got=%b exp=%b", sb.stall, !byp()); end
    tick();
    total++; if (sb.busy_mask !== 32'h0) begin bad++; $display("FAIL lu_clear got=%h exp=0", sb.busy_mask); end
    if (!byp()) begin
      set_wb(0, 0);
      #1;
      total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL lu_late_issue got=%b exp=1", sb.issue_fire); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_waw();
    set_id(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    set_id(1, 1, 1, 2, 1, 7, 1, 0);
    #1;
    total++; if (sb.stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b exp=1", sb.stall); end
    tick();
    total++; if (sb.outstanding !== 3'd1) begin bad++; $display("FAIL waw_cnt got=%0d exp=1", sb.outstanding); end
    drain();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      set_id(1, 0, 0, 0, 0, r, 1, 1);
      #1;
      total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL cap_fill%0d got=%b exp=1", r, sb.issue_fire); end
      tick();
    end
    set_id(1, 0, 0, 0, 0, 6, 1, 1);
    #1;
    total++; if (sb.stall !== 1'b1) begin bad++; $display("FAIL cap_stall got=%b exp=1", sb.stall); end
    total++; if (sb.outstanding !== 3'd4) begin bad++; $display("FAIL cap_cnt got=%0d exp=4", sb.outstanding); end
    set_wb(1, 2);
    #1;
    total++; if (sb.issue_fire !== byp()) begin bad++; $display("FAIL cap_rel_issue got=%b exp=%b", sb.issue_fire, byp()); end
    tick();
    if (!byp()) begin
      total++; if (sb.outstanding !== 3'd3) begin bad++; $display("FAIL cap_rel_cnt got=%0d exp=3", sb.outstanding); end
      set_wb(0, 0);
      #1;
      total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL cap_late_issue got=%b exp=1", sb.issue_fire); end
      tick();
    end
    total++; if (sb.outstanding !== 3'd4) begin bad++; $display("FAIL cap_final_cnt got=%0d exp=4", sb.outstanding); end
    total++; if (sb.busy_mask !== 32'h5A) begin bad++; $display("FAIL cap_final_mask got=%h exp=5a", sb.busy_mask); end
    drain();
  endtask

  task automatic test_simultaneous();
    set_id(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 0, 0, 0, 0, 9, 1, 1);
    set_wb(1, 3);
    #1;
    total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL sim_issue got=%b exp=1", sb.issue_fire); end
    tick();
    total++; if (sb.busy_mask !== 32'h200) begin bad++; $display("FAIL sim_mask got=%h exp=200", sb.busy_mask); end
    total++; if (sb.outstanding !== 3'd1) begin bad++; $display("FAIL sim_cnt got=%0d exp=1", sb.outstanding); end
    drain();
  endtask

  task automatic test_flush_x0();
    set_id(1, 0, 0, 0, 0, 10, 1, 1);
    tick();
    set_id(1, 10, 1, 0, 0, 11, 1, 0);
    #1;
    total++; if (sb.stall !== 1'b1) begin bad++; $display("FAIL fl_stall got=%b exp=1", sb.stall); end
    sb.flush = 1'b1;
    #1;
    total++; if (sb.issue_fire !== 1'b0 || sb.stall !== 1'b0)
      begin bad++; $display("FAIL fl_flush got=%b%b exp=00", sb.stall, sb.issue_fire); end
    tick();
    total++; if (sb.busy_mask !== 32'h400) begin bad++; $display("FAIL fl_mask got=%h exp=400", sb.busy_mask); end
    sb.flush = 1'b0;
    set_id(1, 0, 0, 0, 0, 0, 1, 1);
    #1;
    total++; if (sb.issue_fire !== 1'b1) begin bad++; $display("FAIL x0_issue got=%b exp=1", sb.issue_fire); end
    tick();
    set_id(1, 0, 0, 0, 0, 13, 0, 1);
    tick();
    total++; if (sb.busy_mask !== 32'h400 || sb.outstanding !== 3'd1)
      begin bad++; $display("FAIL x0_state got=%h/%0d exp=400/1", sb.busy_mask, sb.outstanding); end
    drain();
  endtask

  task automatic test_spurious_reset();
    idle();
    set_wb(1, 12);
    tick();
    idle();
    repeat (3) tick();
    total++; if (sb.err_spurious_wb !== 1'b1) begin bad++; $display("FAIL sp_err got=%b exp=1", sb.err_spurious_wb); end
    set_id(1, 0, 0, 0, 0, 13, 1, 1);
    tick();
    set_id(1, 0, 0, 0, 0, 14, 1, 1);
    tick();
    idle();
    total++; if (sb.outstanding !== 3'd2) begin bad++; $display("FAIL rs_pre_cnt got=%0d exp=2", sb.outstanding); end
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    total++; if (sb.busy_mask !== 32'h0 || sb.outstanding !== 3'd0 || sb.err_spurious_wb !== 1'b0)
      begin bad++; $display("FAIL rs_async got=%h/%0d/%b exp=0/0/0", sb.busy_mask, sb.outstanding, sb.err_spurious_wb); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_wb(1, 13);
    tick();
    idle();
    total++; if (sb.err_spurious_wb !== 1'b1 || sb.outstanding !== 3'd0)
      begin bad++; $display("FAIL rs_late_wb got=%b/%0d exp=1/0", sb.err_spurious_wb, sb.outstanding); end
    rst = 1'b1;
    m_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    bit exp_stall, exp_issue;
    int r;
    for (int n = 0; n < 500; n++) begin
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 1),
             $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
             $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
      sb.flush = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 7);
      if ($urandom_range(0, 9) < 4 && (m_busy[r] || $urandom_range(0, 19) == 0)) set_wb(1, r);
      else set_wb(0, 0);
      #1;
      exp_stall = m_stall();
      exp_issue = m_issue();
      total++; if (sb.stall !== exp_stall) begin bad++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, sb.stall, exp_stall); end
      total++; if (sb.issue_fire !== exp_issue) begin bad++; $display("FAIL rnd_issue[%0d] got=%b exp=%b", n, sb.issue_fire, exp_issue); end
      tick();
      total++; if (sb.busy_mask !== m_mask()) begin bad++; $display("FAIL rnd_mask[%0d] got=%h exp=%h", n, sb.busy_mask, m_mask()); end
      total++; if (int'(sb.outstanding) !== m_cnt) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, sb.outstanding, m_cnt); end
      total++; if (sb.err_spurious_wb !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, sb.err_spurious_wb, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_load_use();
    test_waw();
    test_capacity();
    test_simultaneous();
    test_flush_x0();
    test_spurious_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
